div_iter: RTL and testbench

//  Iterative 32-bit integer divider in the EX stage, downstream of the ALU-control decoder.

---
 rtl/div_iter_pkg.sv | 15 +
 rtl/div_iter_if.sv | 27 ++
 rtl/div_iter.sv | 109 ++++++++++
 tb/tb_div_iter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// Shared ALU-control encodings and operand width for the iterative divider.
package div_iter_pkg;

  localparam int DIV_WIDTH = 32;

  // ALU control codes, identical to the EX-stage decoder encodings
  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;
  localparam logic [7:0] EXE_ADD_OP  = 8'b00100000;

  function automatic logic is_div_op(input logic [7:0] code);
    return (code == EXE_DIV_OP) || (code == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// EX-stage to divider bundle: operation request, hazard stall and HI/LO result.
interface div_iter_if
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic [7:0]         alucontrol;
  logic               start;
  logic               flush;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               stall_div;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  modport master (
    output alucontrol, start, flush, a, b,
    input  stall_div, ready, result
  );

  modport slave (
    input  alucontrol, start, flush, a, b,
    output stall_div, ready, result
  );

endinterface

// File: rtl/div_iter.sv
// Iterative restoring 32-bit divider (DIV/DIVU), quotient to LO, remainder to HI.
// Latency: accept cycle + 32 BUSY cycles; ready is a one-cycle pulse in cycle 34.
// Backpressure: stall_div holds IF..EX from accept until the cycle before ready.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  div_iter_if.slave  dif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    counter;
  logic [2*WIDTH:0] work;
  logic [WIDTH-1:0] divisor;
  logic             sign_q;
  logic             sign_r;
  logic             divzero;

  logic             is_signed;
  logic             accept;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH:0] step;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] final_q;
  logic [WIDTH-1:0] final_r;

  assign is_signed = (dif.alucontrol == EXE_DIV_OP);
  assign accept    = (state == IDLE) && dif.start && is_div_op(dif.alucontrol) && !dif.flush;
  assign a_mag     = (is_signed && dif.a[WIDTH-1]) ? -dif.a : dif.a;
  assign b_mag     = (is_signed && dif.b[WIDTH-1]) ? -dif.b : dif.b;

  assign dif.stall_div = accept || (state == BUSY);

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = work << 1;
    diff    = shifted[2*WIDTH:WIDTH] - {1'b0, divisor};
    step    = shifted;
    if (!diff[WIDTH]) begin
      step = {diff, shifted[WIDTH-1:1], 1'b1};
    end
    quo     = step[WIDTH-1:0];
    rem     = step[2*WIDTH-1:WIDTH];
    final_q = divzero ? {WIDTH{1'b1}} : (sign_q ? -quo : quo);
    // With b == 0 the remainder is |a|; re-applying sign_r restores the raw dividend.
    final_r = sign_r ? -rem : rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      counter    <= '0;
      work       <= '0;
      divisor    <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      divzero    <= 1'b0;
      dif.ready  <= 1'b0;
      dif.result <= '0;
    end else begin
      dif.ready <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            work    <= {{(WIDTH+1){1'b0}}, a_mag};
            divisor <= b_mag;
            sign_q  <= is_signed && (dif.a[WIDTH-1] ^ dif.b[WIDTH-1]);
            sign_r  <= is_signed && dif.a[WIDTH-1];
            divzero <= (dif.b == '0);
            counter <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (dif.flush) begin
            state <= IDLE;
          end else begin
            work    <= step;
            counter <= counter + 1'b1;
            if (counter == LAST) begin
              state      <= DONE;
              dif.ready  <= 1'b1;
              dif.result <= {final_r, final_q};
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed-vector bench for div_iter: latency, stall window, signed/unsigned results,
// divide by zero, overflow, flush, mid-division reset and back-to-back operations.
module tb_div_iter;
  import div_iter_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [63:0] last_exp;

  div_iter_if #(.WIDTH(32)) dif ();

  div_iter #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // Drives one division at the next falling edge (cycle 1) and holds the request,
  // as a stalled EX stage would, until ready is seen.
  task automatic run_div(input string tag, input logic [7:0] op,
                         input logic [31:0] da, input logic [31:0] db,
                         input logic [63:0] exp);
    int cyc;
    int stall_n;
    int rdy_cyc;
    @(negedge clk);
    dif.alucontrol = op;
    dif.a          = da;
    dif.b          = db;
    dif.flush      = 1'b0;
    dif.start      = 1'b1;
    #1;
    stall_n = dif.stall_div ? 1 : 0;
    cyc     = 1;
    rdy_cyc = 0;
    while (rdy_cyc == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (dif.ready) begin
        rdy_cyc = cyc;
        chk({tag, " stall_at_ready"}, 64'(dif.stall_div), 64'd0);
        chk({tag, " result"}, dif.result, exp);
      end else if (dif.stall_div) begin
        stall_n++;
      end
    end
    dif.start = 1'b0;
    chk({tag, " ready_cycle"}, 64'(rdy_cyc), 64'd34);
    chk({tag, " stall_cycles"}, 64'(stall_n), 64'd33);
    last_exp = exp;
  endtask

  initial begin
    int cnt;
    checks         = 0;
    errors         = 0;
    last_exp       = '0;
    dif.alucontrol = '0;
    dif.start      = 1'b0;
    dif.flush      = 1'b0;
    dif.a          = '0;
    dif.b          = '0;

    rst = 1'b1;
    #1;
    chk("reset ready", 64'(dif.ready), 64'd0);
    chk("reset result", dif.result, 64'd0);
    chk("reset stall", 64'(dif.stall_div), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic unsigned and signed cases
    run_div("divu 7/2", EXE_DIVU_OP, 32'd7, 32'd2, {32'h1, 32'h3});
    @(negedge clk);
    chk("ready single pulse", 64'(dif.ready), 64'd0);
    run_div("div -7/2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("div 7/-2", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD});
    run_div("div -100/-7", EXE_DIV_OP, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'hE});
    run_div("divu big/16", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF});

    // Overflow and its unsigned counterpart
    run_div("div ovf", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    run_div("divu ovf ops", EXE_DIVU_OP, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0});

    // Divide by zero keeps full latency and returns {a, all ones}
    run_div("div 5/0", EXE_DIV_OP, 32'd5, 32'd0, {32'h5, 32'hFFFF_FFFF});
    @(negedge clk);
    chk("div0 ready once", 64'(dif.ready), 64'd0);
    run_div("div -8/0", EXE_DIV_OP, 32'hFFFF_FFF8, 32'd0, {32'hFFFF_FFF8, 32'hFFFF_FFFF});
    run_div("divu x/0", EXE_DIVU_OP, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF});

    // Flush in cycle 10 of a division
    @(negedge clk);
    dif.alucontrol = EXE_DIVU_OP;
    dif.a          = 32'd9;
    dif.b          = 32'd3;
    dif.start      = 1'b1;
    for (int i = 2; i <= 10; i++) @(negedge clk);
    dif.flush = 1'b1;
    dif.start = 1'b0;
    @(negedge clk);
    chk("flush stall", 64'(dif.stall_div), 64'd0);
    chk("flush ready", 64'(dif.ready), 64'd0);
    chk("flush result kept", dif.result, last_exp);
    dif.flush = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dif.ready || dif.stall_div) cnt++;
    end
    chk("flush no ready", 64'(cnt), 64'd0);
    chk("flush result final", dif.result, last_exp);

    // Flush coinciding with a would-be accept
    @(negedge clk);
    dif.alucontrol = EXE_DIV_OP;
    dif.start      = 1'b1;
    dif.flush      = 1'b1;
    #1;
    chk("flush at accept stall", 64'(dif.stall_div), 64'd0);
    @(negedge clk);
    dif.start = 1'b0;
    dif.flush = 1'b0;
    #1;
    chk("flush at accept idle", 64'(dif.stall_div), 64'd0);

    // Non-divide opcode never starts the unit
    @(negedge clk);
    dif.alucontrol = EXE_ADD_OP;
    dif.a          = 32'd12;
    dif.b          = 32'd4;
    dif.start      = 1'b1;
    #1;
    chk("add stall", 64'(dif.stall_div), 64'd0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dif.ready || dif.stall_div) cnt++;
    end
    dif.start = 1'b0;
    #1;
    chk("add stays idle", 64'(cnt + int'(dif.stall_div)), 64'd0);

    // Back-to-back: second request presented the cycle after DONE
    run_div("b2b first", EXE_DIVU_OP, 32'd100, 32'd7, {32'h2, 32'hE});
    run_div("b2b second", EXE_DIV_OP, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2});

    // Reset in the middle of BUSY
    @(negedge clk);
    dif.alucontrol = EXE_DIVU_OP;
    dif.a          = 32'd50;
    dif.b          = 32'd5;
    dif.start      = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    dif.start = 1'b0;
    rst       = 1'b1;
    #1;
    chk("rst busy result", dif.result, 64'd0);
    chk("rst busy ready", 64'(dif.ready), 64'd0);
    chk("rst busy stall", 64'(dif.stall_div), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("after rst idle", 64'(dif.stall_div), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
